// File: rtl/uart_mmio_ctrl_if.sv
// CPU peripheral-bus view of the UART: byte register access plus interrupt lines.
interface uart_mmio_ctrl_if;
    logic [1:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq_rx;
    logic       irq_tx;

    modport master (output addr, rd, wr, wdata, input rdata, irq_rx, irq_tx);
    modport slave  (input addr, rd, wr, wdata, output rdata, irq_rx, irq_tx);
endinterface

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART: 8N1 RX (oversampled) and TX, one-byte buffers, TXD/RXD/CON registers.
// Register reads return one cycle after the rd strobe; TXD writes while busy are dropped.
module uart_mmio_ctrl #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  logic             clk,
    input  logic             resetk,
    uart_mmio_ctrl_if.slave  bus,
    input  logic             RX,
    output logic             TX
);
    localparam int DIV     = CLK_FREQ / (BAUD * OVS);
    localparam int BIT_CYC = DIV * OVS;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW      = $clog2(OVS);
    localparam int BW      = $clog2(BIT_CYC);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [OW-1:0] OS_HALF   = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYC - 1);

    localparam logic [1:0] A_TXD = 2'd0;
    localparam logic [1:0] A_RXD = 2'd1;
    localparam logic [1:0] A_CON = 2'd2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;

    logic            rx_s1, rx_s2;
    logic [TW-1:0]   tick_cnt;
    logic            tick;

    rx_state_t       rx_state, rx_state_nxt;
    logic [OW-1:0]   os_cnt, os_cnt_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      rx_shift, rx_shift_nxt;
    logic            rx_ok, rx_bad;

    tx_state_t       tx_state, tx_state_nxt;
    logic [BW-1:0]   tx_cyc;
    logic [3:0]      tx_idx;
    logic [9:0]      tx_frame;
    logic            tx_accept, tx_bit_end, tx_finish, tx_busy;

    logic [7:0]      rx_data;
    logic            rx_valid, overrun, frame_err, tx_done, tx_ie, rx_ie;
    logic            rd_rxd, rd_con, wr_con;
    logic [7:0]      con_val;

    always_ff @(posedge clk or posedge resetk) begin
        if (resetk) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            tick_cnt <= '0;
        end else begin
            rx_s1    <= RX;
            rx_s2    <= rx_s1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Start bit is re-checked half a bit in; data/stop sampled a full bit apart from there.
    always_comb begin
        rx_state_nxt = rx_state;
        os_cnt_nxt   = os_cnt;
        bit_cnt_nxt  = bit_cnt;
        rx_shift_nxt = rx_shift;
        rx_ok        = 1'b0;
        rx_bad       = 1'b0;
        if (tick) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_state_nxt = RX_START;
                        os_cnt_nxt   = '0;
                    end
                end
                RX_START: begin
                    if (os_cnt == OS_HALF) begin
                        os_cnt_nxt   = '0;
                        bit_cnt_nxt  = '0;
                        rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        os_cnt_nxt = os_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt_nxt   = '0;
                        rx_shift_nxt = {rx_s2, rx_shift[7:1]};
                        bit_cnt_nxt  = bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) rx_state_nxt = RX_STOP;
                    end else begin
                        os_cnt_nxt = os_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt_nxt   = '0;
                        rx_state_nxt = RX_IDLE;
                        rx_ok        = rx_s2;
                        rx_bad       = !rx_s2;
                    end else begin
                        os_cnt_nxt = os_cnt + 1'b1;
                    end
                end
                default: rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge resetk) begin
        if (resetk) begin
            rx_state <= RX_IDLE;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            os_cnt   <= os_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    assign tx_busy    = (tx_state == TX_SEND);
    assign tx_accept  = bus.wr && (bus.addr == A_TXD) && !tx_busy;
    assign tx_bit_end = tx_busy && (tx_cyc == BIT_LAST);
    assign tx_finish  = tx_bit_end && (tx_idx == 4'd9);

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_accept) tx_state_nxt = TX_SEND;
            TX_SEND: if (tx_finish) tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // tx_frame holds the not-yet-sent bits; its LSB is always the bit on the line.
    always_ff @(posedge clk or posedge resetk) begin
        if (resetk) begin
            tx_state <= TX_IDLE;
            tx_cyc   <= '0;
            tx_idx   <= '0;
            tx_frame <= '0;
            TX       <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_accept) begin
                tx_frame <= {1'b1, bus.wdata, 1'b0};
                tx_idx   <= '0;
                tx_cyc   <= '0;
                TX       <= 1'b0;
            end else if (tx_busy) begin
                if (tx_bit_end) begin
                    tx_cyc <= '0;
                    if (tx_finish) begin
                        TX <= 1'b1;
                    end else begin
                        tx_idx   <= tx_idx + 1'b1;
                        tx_frame <= {1'b1, tx_frame[9:1]};
                        TX       <= tx_frame[1];
                    end
                end else begin
                    tx_cyc <= tx_cyc + 1'b1;
                end
            end
        end
    end

    assign rd_rxd  = bus.rd && (bus.addr == A_RXD);
    assign rd_con  = bus.rd && (bus.addr == A_CON);
    assign wr_con  = bus.wr && (bus.addr == A_CON);
    assign con_val = {1'b0, frame_err, overrun, tx_done, rx_valid, tx_busy, rx_ie, tx_ie};

    // New events win over read-to-clear so no completion is ever lost.
    always_ff @(posedge clk or posedge resetk) begin
        if (resetk) begin
            bus.rdata  <= '0;
            bus.irq_rx <= 1'b0;
            bus.irq_tx <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            tx_done    <= 1'b0;
            tx_ie      <= 1'b0;
            rx_ie      <= 1'b0;
        end else begin
            if (bus.rd) begin
                case (bus.addr)
                    A_RXD:   bus.rdata <= rx_data;
                    A_CON:   bus.rdata <= con_val;
                    default: bus.rdata <= '0;
                endcase
            end
            if (wr_con) begin
                tx_ie <= bus.wdata[0];
                rx_ie <= bus.wdata[1];
            end
            if (rx_ok) rx_data <= rx_shift;

            if (rx_ok)       rx_valid <= 1'b1;
            else if (rd_rxd) rx_valid <= 1'b0;

            if (rx_ok && rx_valid && !rd_rxd) overrun <= 1'b1;
            else if (rd_con)                  overrun <= 1'b0;

            if (rx_bad)      frame_err <= 1'b1;
            else if (rd_con) frame_err <= 1'b0;

            if (tx_finish)   tx_done <= 1'b1;
            else if (rd_con) tx_done <= 1'b0;

            bus.irq_rx <= rx_ie & rx_valid;
            bus.irq_tx <= tx_ie & tx_done;
        end
    end
endmodule
